disp_sr_rx: RTL and testbench

Receive end of the display shift-register interface: deserializes the disp_sclk/disp_sin/disp_lat stream driven by disp_sr back into a parallel word. It is used as the in-fabric loopback checker and as the bench-side display model. Inputs are treated as asynchronous to clk and are synchronized and edge-detected before use. A 256-bit frame is captured on each latch pulse, together with a bit-count check.

---
 rtl/disp_sr_rx.sv | 95 +++++++++
 tb/tb_disp_sr_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_sr_rx.sv
// disp_sr_rx: deserializes the disp_sclk/disp_sin/disp_lat display stream into a parallel frame with bit-count and protocol checks.
module disp_sr_rx #(
  parameter int WIDTH       = 256,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_sclk,
  input  logic             disp_lat,
  input  logic             disp_sin,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic [15:0]      rx_frames,
  output logic             proto_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, lat_sync_q, sin_sync_q;
  logic sclk_prev_q, lat_prev_q;
  logic sclk_s, lat_s, sin_s, sclk_rise, lat_rise, lat_fall;
  logic shift_en, latch_en, proto_set;
  logic lat_pend_q, rx_valid_q, rx_err_q, proto_q;
  logic [WIDTH-1:0] sr_q, rx_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0] rx_frames_q;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign lat_s     = lat_sync_q[SYNC_STAGES-1];
  assign sin_s     = sin_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign lat_rise  = lat_s & ~lat_prev_q;
  assign lat_fall  = ~lat_s & lat_prev_q;
  // sin is taken from the same sync stage as sclk so data stays aligned to its clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      lat_sync_q  <= '0;
      sin_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      lat_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], disp_sclk};
      lat_sync_q  <= {lat_sync_q[SYNC_STAGES-2:0], disp_lat};
      sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0], disp_sin};
      sclk_prev_q <= sclk_s;
      lat_prev_q  <= lat_s;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == HOLD) ? (lat_fall ? IDLE : HOLD) :
              lat_rise          ? HOLD :
              sclk_rise         ? SHIFT : state_q;
  end
  always_comb begin
    shift_en  = sclk_rise & (state_q != HOLD);
    latch_en  = lat_rise & (state_q != HOLD);
    proto_set = sclk_rise & (state_q == HOLD);
  end
  // the latch fires one cycle after the rise is seen, so a coincident shift is included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      lat_pend_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_frames_q <= '0;
      proto_q     <= 1'b0;
    end else begin
      lat_pend_q <= latch_en;
      rx_valid_q <= lat_pend_q;
      if (proto_set) proto_q <= 1'b1;
      if (shift_en) sr_q <= {sr_q[WIDTH-2:0], sin_s};
      if (lat_pend_q) begin
        rx_data_q   <= sr_q;
        rx_err_q    <= (cnt_q != CNT_W'(WIDTH));
        rx_frames_q <= rx_frames_q + 16'd1;
        cnt_q       <= '0;
      end else if (shift_en && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_err    = rx_err_q;
  assign rx_frames = rx_frames_q;
  assign proto_err = proto_q;
endmodule

// File: tb/tb_disp_sr_rx.sv
// tb_disp_sr_rx: randomized serial stimulus against a frame-level model of the display receiver.
module tb_disp_sr_rx;
  localparam int W = 256, SS = 2, CW = 9;
  logic clk = 1'b0, rst = 1'b1, disp_sclk = 1'b0, disp_lat = 1'b0, disp_sin = 1'b0;
  logic [W-1:0] rx_data;
  logic rx_valid, rx_err, proto_err;
  logic [15:0] rx_frames;
  always #5 clk = ~clk;

  disp_sr_rx #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .disp_sclk(disp_sclk), .disp_lat(disp_lat), .disp_sin(disp_sin),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .rx_frames(rx_frames),
    .proto_err(proto_err)
  );

  typedef struct { logic [W-1:0] d; logic e; logic [15:0] f; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, n_valid = 0;
  int m_cnt = 0;
  logic [W-1:0] m_sr = '0, last_d = '0;
  logic [15:0] m_frames = '0, last_f = '0;
  logic m_hold = 1'b0, m_proto = 1'b0, last_e = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_valid === 1'b1) begin
      n_valid++;
      last_d = rx_data;
      last_e = rx_err;
      last_f = rx_frames;
      if (exp_q.size() == 0) check("unexpected rx_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.d);
        check("rx_err", rx_err, e.e);
        check("rx_frames", rx_frames, e.f);
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    disp_sin = b;
    clks(3);
    disp_sclk = 1'b1;
    clks(3);
    disp_sclk = 1'b0;
    if (m_hold) m_proto = 1'b1;
    else begin
      m_sr = {m_sr[W-2:0], b};
      if (m_cnt < 2**CW - 1) m_cnt++;
    end
  endtask

  task automatic send_vec(input logic [W-1:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic lat_up();
    exp_t e;
    m_frames = m_frames + 16'd1;
    e.d = m_sr;
    e.e = (m_cnt != W);
    e.f = m_frames;
    exp_q.push_back(e);
    m_cnt = 0;
    m_hold = 1'b1;
    disp_lat = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      clks(1);
      check($sformatf("rx_valid latency k=%0d", k), rx_valid, k == SS + 2);
    end
  endtask

  task automatic lat_down();
    disp_lat = 1'b0;
    m_hold = 1'b0;
    clks(4);
  endtask

  task automatic latch();
    lat_up();
    lat_down();
  endtask

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_zero(input string nm);
    check({nm, " rx_data"}, rx_data, 0);
    check({nm, " rx_valid"}, rx_valid, 0);
    check({nm, " rx_err"}, rx_err, 0);
    check({nm, " rx_frames"}, rx_frames, 0);
    check({nm, " proto_err"}, proto_err, 0);
  endtask

  initial begin
    logic [W-1:0] v;
    int n;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      disp_sclk = 1'($urandom);
      disp_lat = 1'($urandom);
      disp_sin = 1'($urandom);
      clks(1);
    end
    check_zero("reset");
    disp_sclk = 1'b0;
    disp_lat = 1'b0;
    disp_sin = 1'b0;
    clks(1);
    rst = 1'b0;
    clks(20);
    check("no rx_valid after reset", n_valid, 0);

    v = {4'h5, {62{4'ha}}, 4'h5};
    send_vec(v, W);
    latch();
    check("frame1 data", last_d, {4'h5, {62{4'ha}}, 4'h5});
    check("frame1 err", last_e, 0);
    check("frame1 count", last_f, 1);
    v = {4'ha, {62{4'h5}}, 4'ha};
    send_vec(v, W);
    latch();
    check("frame2 data", last_d, {4'ha, {62{4'h5}}, 4'ha});
    check("frame2 count", last_f, 2);
    v = {32{8'ha5}};
    send_vec(v, W);
    latch();
    check("frame3 data", last_d, {32{8'ha5}});
    check("frame3 count", last_f, 3);

    send_vec({1'b1, 255'b0}, W);
    latch();
    check("bit order", last_d, {1'b1, 255'b0});
    send_vec({W{1'b1}}, 255);
    latch();
    check("underrun data", last_d, {1'b0, {255{1'b1}}});
    check("underrun err", last_e, 1);
    send_bit(1'b1);
    send_vec('0, W);
    latch();
    check("overrun data", last_d, 0);
    check("overrun err", last_e, 1);

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(250, 262);
      for (int i = W; i < n; i++) send_bit(1'($urandom));
      send_vec(rnd_vec(), (n < W) ? n : W);
      latch();
    end

    check("proto_err before", proto_err, 0);
    lat_up();
    send_bit(1'($urandom));
    lat_down();
    check("proto_err set", proto_err, 1);
    check("proto_err model", proto_err, m_proto);
    send_vec(rnd_vec(), W);
    latch();
    check("good frame after proto err", last_e, 0);
    check("proto_err sticky", proto_err, 1);

    m_frames = 16'hFFFF;
    force dut.rx_frames_q = 16'hFFFF;
    clks(1);
    release dut.rx_frames_q;
    clks(1);
    check("forced rx_frames", rx_frames, 16'hFFFF);
    send_vec(rnd_vec(), W);
    latch();
    check("rx_frames wrap", last_f, 0);

    send_vec(rnd_vec(), 100);
    rst = 1'b1;
    m_sr = '0;
    m_cnt = 0;
    m_frames = '0;
    m_proto = 1'b0;
    m_hold = 1'b0;
    clks(3);
    check_zero("mid-frame reset");
    rst = 1'b0;
    clks(3);
    v = rnd_vec();
    send_vec(v, W);
    latch();
    check("post-reset err", last_e, 0);
    check("post-reset data", last_d, v);
    check("post-reset count", last_f, 1);
    check("pending expectations", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
